// File: rtl/multicycle_adder.sv
// Area-lean adder/subtractor: adds CHUNK bits per cycle through a registered carry,
// with a start/busy/done handshake and Cout/Overflow/Zero flags held until the next completion.
module multicycle_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             CLK,
  input  logic             NSYSRESET,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic [KW-1:0]    r_k;
  logic [CHUNK:0]   w_chunkSum;
  logic [WIDTH-1:0] w_partNext;
  logic             w_last;
  logic             w_accept;
  logic             w_ovf;

  // Operands shift right by CHUNK each cycle, so the active chunk is always the low bits.
  assign w_last     = (r_k == KW'(N - 1));
  assign w_accept   = start && (r_state != S_ADD);
  assign w_chunkSum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
  // On the final chunk: operand MSBs agree but the result MSB differs.
  assign w_ovf      = (r_a[CHUNK-1] ~^ r_b[CHUNK-1]) & (r_a[CHUNK-1] ^ w_chunkSum[CHUNK-1]);

  // New chunk enters at the top; after N cycles the first chunk has reached bit 0.
  generate
    if (CHUNK == WIDTH) begin : g_single
      assign w_partNext = w_chunkSum[CHUNK-1:0];
    end else begin : g_multi
      assign w_partNext = {w_chunkSum[CHUNK-1:0], r_part[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_ff @(posedge CLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nextState = S_ADD;
      S_ADD:   if (w_last) w_nextState = S_DONE;
      S_DONE:  w_nextState = start ? S_ADD : S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= B ^ {WIDTH{Sub}};
      r_carry <= Cin ^ Sub;
      r_part  <= '0;
      r_k     <= '0;
    end else if (r_state == S_ADD) begin
      r_a     <= r_a >> CHUNK;
      r_b     <= r_b >> CHUNK;
      r_carry <= w_chunkSum[CHUNK];
      r_part  <= w_partNext;
      r_k     <= r_k + KW'(1);
      if (w_last) begin
        r_sum  <= w_partNext;
        r_cout <= w_chunkSum[CHUNK];
        r_ovf  <= w_ovf;
        r_zero <= (w_partNext == '0);
      end
    end
  end

  assign busy     = (r_state == S_ADD);
  assign done     = (r_state == S_DONE);
  assign Sum      = r_sum;
  assign Cout     = r_cout;
  assign Overflow = r_ovf;
  assign Zero     = r_zero;
endmodule

// File: doc/multicycle_adder.md
# multicycle_adder

Parametrised, clocked adder/subtractor that computes a WIDTH-bit sum over WIDTH/CHUNK cycles, processing CHUNK bits per cycle with a registered carry. It generalises the team's single-bit full adder (A, B, Cin → Sum, Cout) to arbitrary width, adds a subtract mode and status flags, and uses a start/busy/done handshake. It sits beside the combinational adders as the area-lean ALU datapath option for the MIPS work.

## Interface
- WIDTH, 8, operand/result width; must be ≥ 1.
- CHUNK, 2, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH, WIDTH % CHUNK == 0; N = WIDTH/CHUNK.
- CLK  input  1  sole clock, rising edge.
- NSYSRESET  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled on a rising edge of CLK while in IDLE or DONE.
- A  input  WIDTH  operand A; captured on accept.
- B  input  WIDTH  operand B; captured on accept.
- Cin  input  1  carry-in; captured on accept.
- Sub  input  1  1 = subtract; captured on accept.
- busy  output  1  high in ADD state.
- done  output  1  one-cycle pulse, high in DONE state.
- Sum  output  WIDTH  result; registered.
- Cout  output  1  carry out of MSB (for Sub=1, 1 = no borrow).
- Overflow  output  1  two's-complement signed overflow.
- Zero  output  1  Sum == 0.

## Operation
- Effective operands: Beff = B ^ {WIDTH{Sub}}, c0 = Cin ^ Sub. Result = A + Beff + c0, mod 2^WIDTH. Sub=1, Cin=0 gives A − B.
- States: IDLE, ADD, DONE.
- IDLE: start=1 → capture A, Beff, c0 into internal registers, chunk index k=0, go ADD. Otherwise stay.
- ADD: each cycle add chunk k (bits k·CHUNK+CHUNK−1 … k·CHUNK) of A and Beff plus the carry register. Write the partial sum bits and update the carry register. At k = N−1, go DONE; else k+1.
- DONE: load Sum, Cout, Overflow, Zero on the entering edge. start=1 → accept a new operation as in IDLE (back-to-back), else go IDLE.
- Overflow = carry into MSB XOR carry out of MSB, computed in the final chunk.
- start in ADD is ignored. A/B/Cin/Sub changes after accept have no effect.
- Sum/Cout/Overflow/Zero hold the last completed result until the next completion. They do not change during ADD.
- Reset asserted at any time, including mid-operation: state=IDLE immediately, operation aborted, all outputs 0, internal registers 0.

## Timing
- Reset values: busy=0, done=0, Sum=0, Cout=0, Overflow=0, Zero=0. Zero reads 0 after reset even though Sum=0; the flag is only valid after a completion.
- start high in cycle 0 is accepted at edge 0. busy is high in cycles 1..N, done=1 and the new results are visible in cycle N+1. Latency from start to done is N+1 cycles.
- CHUNK=WIDTH: N=1, so busy lasts 1 cycle and done is in cycle 2.
- Back-to-back: start high during the done cycle gives busy in the next cycle, with no IDLE gap. Throughput is one result per N+1 cycles.
- done is never high for two consecutive cycles. busy and done are never both high.
- Reset release is synchronous to CLK in effect: the first start accepted is the one sampled on the first rising edge with NSYSRESET=1.

## Test plan
- Reset: hold NSYSRESET=0 for 3 cycles with random inputs and start=1 → all outputs 0. Assert reset mid-ADD (cycle 2 of WIDTH=8, CHUNK=2) → busy=0 and outputs 0 immediately, with no done pulse.
- WIDTH=8, CHUNK=2: A=8'h5A, B=8'h3C, Cin=0, Sub=0, start in cycle 0 → busy in cycles 1–4. Done in cycle 5 with Sum=8'h96, Cout=0, Overflow=1, Zero=0.
- Wrap: A=8'hFF, B=8'h01, Cin=0 → Sum=8'h00, Cout=1, Overflow=0, Zero=1. Next, A=8'h7F, B=8'h00, Cin=1 → Sum=8'h80, Overflow=1, Cout=0.
- Subtract: A=8'h10, B=8'h20, Sub=1, Cin=0 → Sum=8'hF0, Cout=0, Overflow=0. Then A=8'h80, B=8'h01, Sub=1 → Sum=8'h7F, Cout=1, Overflow=1.
- Handshake: hold start=1 continuously with operands changing every cycle → only the operands present at accept edges are used. done pulses in cycles 5, 10, 15, …, and Sum is stable throughout ADD.
- Exhaustive, WIDTH=4, CHUNK=1 and CHUNK=4: all 1024 combinations of A, B, Cin and Sub are checked against a behavioural model for all four outputs.
